// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings and helpers for the data-memory access controller.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DBG = 1'b1;

    // Counter width able to hold wait_cycles, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable down-counter timing the memory wait states; done_c flags zero.
module dmem_wait_counter
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic done_c
);

    localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(WAIT_CYCLES);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_c = (cnt_q == '0);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Shares the data memory between the MEM stage and a debug/loader port,
// inserting wait states and stalling the pipeline until each access completes.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned STARVE_MAX  = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_mem_read,
    input  logic              cpu_mem_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_valid,
    input  logic              dbg_write,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                is_write_q, is_write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic                dbg_ready_q, dbg_ready_d;

    logic cpu_req_c;
    logic dbg_win_c;
    logic start_c;
    logic wait_done_c;

    assign cpu_req_c = cpu_mem_read | cpu_mem_write;
    // Debug wins when the CPU is idle or it has been passed over STARVE_MAX times.
    assign dbg_win_c = dbg_valid & (~cpu_req_c | (starve_q == STARVE_W'(STARVE_MAX)));
    assign start_c   = (state_q == IDLE) & (cpu_req_c | dbg_valid);

    dmem_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_c),
        .dec   (state_q == BUSY),
        .done_c(wait_done_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_c) state_d = BUSY;
            BUSY:    if (wait_done_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Arbitration, request latching and read-data capture.
    always_comb begin
        grant_d     = grant_q;
        starve_d    = starve_q;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        dbg_ready_d = 1'b0;

        if (state_q == IDLE) begin
            if (!dbg_valid) begin
                starve_d = '0;
            end
            if (start_c) begin
                if (dbg_win_c) begin
                    grant_d    = GNT_DBG;
                    starve_d   = '0;
                    is_write_d = dbg_write;
                    addr_d     = dbg_addr;
                    wdata_d    = dbg_wdata;
                end else begin
                    grant_d    = GNT_CPU;
                    is_write_d = cpu_mem_write;
                    addr_d     = cpu_addr;
                    wdata_d    = cpu_wdata;
                    if (dbg_valid && (starve_q != STARVE_W'(STARVE_MAX))) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end
            end
        end

        if ((state_q == BUSY) && wait_done_c) begin
            if (grant_q == GNT_CPU) begin
                cpu_rdata_d = mem_rdata;
            end else begin
                dbg_rdata_d = mem_rdata;
                dbg_ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q     <= GNT_CPU;
            starve_q    <= '0;
            is_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            dbg_ready_q <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            starve_q    <= starve_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            dbg_ready_q <= dbg_ready_d;
        end
    end

    // Write strobe only in the last BUSY cycle so each access gives one write edge.
    always_comb begin
        mem_read  = (state_q == BUSY) & ~is_write_q;
        mem_write = (state_q == BUSY) & is_write_q & wait_done_c;
        cpu_stall = cpu_req_c & ~((state_q == DONE) & (grant_q == GNT_CPU));
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        cpu_rdata = cpu_rdata_q;
        dbg_rdata = dbg_rdata_q;
        dbg_ready = dbg_ready_q;
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: cycle table plus arbitration, reset and zero-wait sequences.
module tb_dmem_access_ctrl;

    localparam logic [31:0] D_BEEF = 32'hDEADBEEF;
    localparam logic [31:0] D_SEQ  = 32'h12345678;
    localparam logic [31:0] D_BAD  = 32'h0BADF00D;

    logic        clk;
    logic        rst_n;
    logic        cpu_mem_read, cpu_mem_write;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_valid, dbg_write, dbg_ready;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        z_rd;
    logic [31:0] z_addr, z_cpu_rdata, z_dbg_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;
    logic        z_stall, z_dbg_ready, z_mem_read, z_mem_write;

    logic        mem_init;
    logic [31:0] mem [64];
    int          wr_cnt = 0;

    int n_vec  = 0;
    int n_miss = 0;

    dmem_access_ctrl #(.WAIT_CYCLES(1), .STARVE_MAX(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_valid(dbg_valid), .dbg_write(dbg_write), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ready(dbg_ready), .dbg_rdata(dbg_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_access_ctrl #(.WAIT_CYCLES(0), .STARVE_MAX(4), .ADDR_W(32), .DATA_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cpu_mem_read(z_rd), .cpu_mem_write(1'b0),
        .cpu_addr(z_addr), .cpu_wdata(32'h0), .cpu_rdata(z_cpu_rdata), .cpu_stall(z_stall),
        .dbg_valid(1'b0), .dbg_write(1'b0), .dbg_addr(32'h0), .dbg_wdata(32'h0),
        .dbg_ready(z_dbg_ready), .dbg_rdata(z_dbg_rdata),
        .mem_read(z_mem_read), .mem_write(z_mem_write), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory with combinational read and clocked write.
    assign mem_rdata   = mem[mem_addr[7:2]];
    assign z_mem_rdata = 32'hCAFEF00D;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A50000 | 32'(i);
        end else if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    always @(posedge clk) if (mem_write) wr_cnt <= wr_cnt + 1;

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wdata;
        logic        dv, dw;
        logic [31:0] daddr, dwdata;
        logic        e_stall, e_mr, e_mw, e_dr;
        logic [31:0] e_maddr;
        logic        c_crd;
        logic [31:0] e_crd;
        logic        c_drd;
        logic [31:0] e_drd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                                logic dv, logic dw, logic [31:0] daddr, logic [31:0] dwdata,
                                logic st, logic mr, logic mw, logic dr, logic [31:0] maddr,
                                logic ccrd, logic [31:0] crd, logic cdrd, logic [31:0] drd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.dv = dv; v.dw = dw; v.daddr = daddr; v.dwdata = dwdata;
        v.e_stall = st; v.e_mr = mr; v.e_mw = mw; v.e_dr = dr; v.e_maddr = maddr;
        v.c_crd = ccrd; v.e_crd = crd; v.c_drd = cdrd; v.e_drd = drd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        cpu_mem_read = v.rd; cpu_mem_write = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
        dbg_valid = v.dv; dbg_write = v.dw; dbg_addr = v.daddr; dbg_wdata = v.dwdata;
    endtask

    initial begin
        int ncpu, nd, nst, nzr, wr_before;

        rst_n = 1'b0; mem_init = 1'b1;
        cpu_mem_read = 0; cpu_mem_write = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_valid = 0; dbg_write = 0; dbg_addr = 0; dbg_wdata = 0;
        z_rd = 0; z_addr = 0;

        // idle/cpu-read/cpu-write/dbg-read/dbg-write inputs, then stall mr mw dr mem_addr, optional rdata
        tbl.push_back(mk(0,0,0,0,         1,1,'h10,D_BEEF, 0,0,0,0,'h00, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,         1,1,'h10,D_BEEF, 0,0,0,0,'h10, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,         1,1,'h10,D_BEEF, 0,0,1,0,'h10, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,         1,1,'h10,D_BEEF, 0,0,0,1,'h10, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,         0,0,0,0,         0,0,0,0,'h10, 0,0,0,0));
        tbl.push_back(mk(1,0,'h10,0,      0,0,0,0,         1,0,0,0,'h10, 0,0,0,0));
        tbl.push_back(mk(1,0,'h10,0,      0,0,0,0,         1,1,0,0,'h10, 0,0,0,0));
        tbl.push_back(mk(1,0,'h10,0,      0,0,0,0,         1,1,0,0,'h10, 0,0,0,0));
        tbl.push_back(mk(1,0,'h10,0,      0,0,0,0,         0,0,0,0,'h10, 1,D_BEEF,0,0));
        tbl.push_back(mk(0,0,0,0,         0,0,0,0,         0,0,0,0,'h10, 0,0,0,0));
        tbl.push_back(mk(0,1,'h20,D_SEQ,  0,0,0,0,         1,0,0,0,'h10, 0,0,0,0));
        tbl.push_back(mk(0,1,'h20,D_SEQ,  0,0,0,0,         1,0,0,0,'h20, 0,0,0,0));
        tbl.push_back(mk(0,1,'h20,D_SEQ,  0,0,0,0,         1,0,1,0,'h20, 0,0,0,0));
        tbl.push_back(mk(0,1,'h20,D_SEQ,  0,0,0,0,         0,0,0,0,'h20, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,         0,0,0,0,         0,0,0,0,'h20, 0,0,0,0));
        tbl.push_back(mk(1,0,'h20,0,      0,0,0,0,         1,0,0,0,'h20, 0,0,0,0));
        tbl.push_back(mk(1,0,'h20,0,      0,0,0,0,         1,1,0,0,'h20, 0,0,0,0));
        tbl.push_back(mk(1,0,'h20,0,      0,0,0,0,         1,1,0,0,'h20, 0,0,0,0));
        tbl.push_back(mk(1,0,'h20,0,      0,0,0,0,         0,0,0,0,'h20, 1,D_SEQ,0,0));
        tbl.push_back(mk(0,0,0,0,         0,0,0,0,         0,0,0,0,'h20, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,         1,0,'h20,0,      0,0,0,0,'h20, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,         1,0,'h20,0,      0,1,0,0,'h20, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,         1,0,'h20,0,      0,1,0,0,'h20, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,         1,0,'h20,0,      0,0,0,1,'h20, 0,0,1,D_SEQ));
        tbl.push_back(mk(0,0,0,0,         0,0,0,0,         0,0,0,0,'h20, 0,0,0,0));
        tbl.push_back(mk(1,0,'h10,0,      1,0,'h20,0,      1,0,0,0,'h20, 0,0,0,0));
        tbl.push_back(mk(1,0,'h10,0,      1,0,'h20,0,      1,1,0,0,'h10, 0,0,0,0));
        tbl.push_back(mk(1,0,'h10,0,      1,0,'h20,0,      1,1,0,0,'h10, 0,0,0,0));
        tbl.push_back(mk(1,0,'h10,0,      1,0,'h20,0,      0,0,0,0,'h10, 1,D_BEEF,0,0));
        tbl.push_back(mk(0,0,0,0,         1,0,'h20,0,      0,0,0,0,'h10, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,         1,0,'h20,0,      0,1,0,0,'h20, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,         1,0,'h20,0,      0,1,0,0,'h20, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,         1,0,'h20,0,      0,0,0,1,'h20, 0,0,1,D_SEQ));
        tbl.push_back(mk(0,0,0,0,         0,0,0,0,         0,0,0,0,'h20, 0,0,0,0));
        tbl.push_back(mk(0,1,'h24,D_BAD,  0,0,0,0,         1,0,0,0,'h20, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,         0,0,0,0,         0,0,0,0,'h24, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,         0,0,0,0,         0,0,1,0,'h24, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,         0,0,0,0,         0,0,0,0,'h24, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,         0,0,0,0,         0,0,0,0,'h24, 0,0,0,0));
        tbl.push_back(mk(1,0,'h24,0,      0,0,0,0,         1,0,0,0,'h24, 0,0,0,0));
        tbl.push_back(mk(1,0,'h24,0,      0,0,0,0,         1,1,0,0,'h24, 0,0,0,0));
        tbl.push_back(mk(1,0,'h24,0,      0,0,0,0,         1,1,0,0,'h24, 0,0,0,0));
        tbl.push_back(mk(1,0,'h24,0,      0,0,0,0,         0,0,0,0,'h24, 1,D_BAD,0,0));
        tbl.push_back(mk(0,0,0,0,         0,0,0,0,         0,0,0,0,'h24, 0,0,0,0));

        // Reset state, including the combinational stall during reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset cpu_stall", 32'(cpu_stall), 32'd0);
        chk("reset mem_read", 32'(mem_read), 32'd0);
        chk("reset mem_write", 32'(mem_write), 32'd0);
        chk("reset dbg_ready", 32'(dbg_ready), 32'd0);
        chk("reset cpu_rdata", cpu_rdata, 32'd0);
        chk("reset dbg_rdata", dbg_rdata, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        cpu_mem_read = 1'b1;
        #1 chk("reset stall follows req", 32'(cpu_stall), 32'd1);
        cpu_mem_read = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1; mem_init = 1'b0;

        foreach (tbl[i]) begin
            @(posedge clk); #1 drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("row%0d cpu_stall", i), 32'(cpu_stall), 32'(tbl[i].e_stall));
            chk($sformatf("row%0d mem_read", i), 32'(mem_read), 32'(tbl[i].e_mr));
            chk($sformatf("row%0d mem_write", i), 32'(mem_write), 32'(tbl[i].e_mw));
            chk($sformatf("row%0d dbg_ready", i), 32'(dbg_ready), 32'(tbl[i].e_dr));
            chk($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].e_maddr);
            if (tbl[i].c_crd) chk($sformatf("row%0d cpu_rdata", i), cpu_rdata, tbl[i].e_crd);
            if (tbl[i].c_drd) chk($sformatf("row%0d dbg_rdata", i), dbg_rdata, tbl[i].e_drd);
        end

        // Starvation: CPU requests back to back while debug waits.
        @(posedge clk); #1
        cpu_mem_read = 1; cpu_addr = 'h10; dbg_valid = 1; dbg_write = 0; dbg_addr = 'h20;
        ncpu = 0; nd = 0;
        for (int cyc = 0; cyc < 100 && nd < 2; cyc++) begin
            @(negedge clk);
            if (cpu_mem_read && !cpu_stall) begin
                ncpu++;
                chk("starve cpu_rdata", cpu_rdata, D_BEEF);
            end
            if (dbg_ready) begin
                nd++;
                chk($sformatf("starve cpu grants before dbg %0d", nd), 32'(ncpu), 32'd4);
                chk("starve dbg_rdata", dbg_rdata, D_SEQ);
                ncpu = 0;
            end
        end
        chk("starve dbg grants seen", 32'(nd), 32'd2);
        @(posedge clk); #1 cpu_mem_read = 0; dbg_valid = 0;
        repeat (2) @(posedge clk);

        // Reset during the first BUSY cycle of a store must drop the write.
        #1 cpu_mem_write = 1; cpu_addr = 'h30; cpu_wdata = 32'h5555AAAA;
        @(posedge clk);
        @(negedge clk);
        wr_before = wr_cnt;
        rst_n = 1'b0; cpu_mem_write = 0;
        #1;
        chk("busy reset mem_write", 32'(mem_write), 32'd0);
        chk("busy reset mem_read", 32'(mem_read), 32'd0);
        chk("busy reset cpu_rdata", cpu_rdata, 32'd0);
        chk("busy reset dbg_ready", 32'(dbg_ready), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("busy reset write edges", 32'(wr_cnt), 32'(wr_before));
        #1 cpu_mem_read = 1; cpu_addr = 'h30;
        nst = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (!cpu_stall) break;
            nst++;
        end
        chk("load after reset stall cycles", 32'(nst), 32'd3);
        chk("load after reset mem 0x30", cpu_rdata, 32'hA5A5000C);
        @(posedge clk); #1 cpu_mem_read = 0;

        // Zero-wait-state build: two stall cycles per access.
        @(posedge clk); #1 z_rd = 1; z_addr = 'h40;
        nst = 0; nzr = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (z_mem_read) nzr++;
            if (!z_stall) break;
            nst++;
        end
        chk("w0 stall cycles", 32'(nst), 32'd2);
        chk("w0 mem_read cycles", 32'(nzr), 32'd1);
        chk("w0 cpu_rdata", z_cpu_rdata, 32'hCAFEF00D);
        chk("w0 mem_addr", z_mem_addr, 32'h40);
        chk("w0 mem_wdata", z_mem_wdata, 32'h0);
        chk("w0 mem_write", 32'(z_mem_write), 32'd0);
        chk("w0 dbg idle", {z_dbg_rdata[30:0], z_dbg_ready}, 32'h0);
        @(posedge clk); #1 z_rd = 0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
